menu_panel_draw: RTL and testbench

MENU_PANEL_DRAW -- requirements
Module: menu_panel_draw

---
 rtl/menu_panel_draw.sv | 188 ++++++++++++++++++
 tb/tb_menu_panel_draw.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/menu_panel_draw.sv
// Menu overlay: border, background and N_ITEMS boxes with a blinking cursor, a confirm
// flash and a one-cycle choice pulse. Pixel and timing outputs lag their inputs by 1 clk.
module menu_panel_draw #(
  parameter int          H_SIZE       = 1024,
  parameter int          V_SIZE       = 768,
  parameter int          BORDER_W     = 3,
  parameter logic [11:0] BORDER_COLOR = 12'hF00,
  parameter logic [11:0] BG_COLOR     = 12'h888,
  parameter int          N_ITEMS      = 4,
  parameter int          ITEM_X       = 384,
  parameter int          ITEM_Y0      = 200,
  parameter int          ITEM_W       = 256,
  parameter int          ITEM_H       = 64,
  parameter int          ITEM_GAP     = 32,
  parameter logic [11:0] ITEM_COLOR   = 12'h444,
  parameter logic [11:0] SEL_COLOR    = 12'hFF0,
  parameter logic [11:0] CONF_COLOR   = 12'h0F0,
  parameter int          BLINK_FRAMES = 30,
  parameter int          FLASH_FRAMES = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [10:0]                hcount_in,
  input  logic [9:0]                 vcount_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       hblnk_in,
  input  logic                       vblnk_in,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_sel,
  output logic [10:0]                hcount_out,
  output logic [9:0]                 vcount_out,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       hblnk_out,
  output logic                       vblnk_out,
  output logic [11:0]                rgb_out,
  output logic [$clog2(N_ITEMS)-1:0] sel_index,
  output logic                       choice_valid,
  output logic [$clog2(N_ITEMS)-1:0] choice_index
);
  localparam int SW = $clog2(N_ITEMS);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int PITCH = ITEM_H + ITEM_GAP;
  localparam logic [SW-1:0] LAST = SW'(N_ITEMS - 1);
  localparam logic [31:0] X_LO = 32'(ITEM_X);
  localparam logic [31:0] X_HI = 32'(ITEM_X + ITEM_W - 1);
  localparam logic [31:0] B_LO = 32'(BORDER_W);
  localparam logic [31:0] B_RH = 32'(H_SIZE - BORDER_W);
  localparam logic [31:0] B_RV = 32'(V_SIZE - BORDER_W);

  typedef enum logic {NAV = 1'b0, FLASH = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d, disp_sel_q, disp_sel_d, choice_idx_q, choice_idx_d;
  logic          choice_vld_q, choice_vld_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic [10:0]   hcount_q;
  logic [9:0]    vcount_q;
  logic          hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic [11:0]   rgb_q, rgb_d;
  logic          frame_tick, flash_done, in_border, in_box, in_sel_box;
  logic [31:0]   hx, vy, top;

  // vblnk_q is both the delayed vblnk_out and the history bit for the frame edge
  assign frame_tick = vblnk_in & ~vblnk_q;
  assign flash_done = (state_q == FLASH) && frame_tick && (flash_cnt_q == FW'(FLASH_FRAMES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= NAV;
      sel_q        <= '0;
      disp_sel_q   <= '0;
      choice_idx_q <= '0;
      choice_vld_q <= 1'b0;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      flash_cnt_q  <= '0;
      hcount_q     <= '0;
      vcount_q     <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      hblnk_q      <= 1'b0;
      vblnk_q      <= 1'b0;
      rgb_q        <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      disp_sel_q   <= disp_sel_d;
      choice_idx_q <= choice_idx_d;
      choice_vld_q <= choice_vld_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      flash_cnt_q  <= flash_cnt_d;
      hcount_q     <= hcount_in;
      vcount_q     <= vcount_in;
      hsync_q      <= hsync_in;
      vsync_q      <= vsync_in;
      hblnk_q      <= hblnk_in;
      vblnk_q      <= vblnk_in;
      rgb_q        <= rgb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NAV:     if (btn_sel) state_d = FLASH;
      FLASH:   if (flash_done) state_d = NAV;
      default: state_d = NAV;
    endcase
  end

  always_comb begin
    sel_d        = sel_q;
    choice_idx_d = choice_idx_q;
    choice_vld_d = 1'b0;
    blink_cnt_d  = blink_cnt_q;
    blink_on_d   = blink_on_q;
    flash_cnt_d  = flash_cnt_q;
    disp_sel_d   = frame_tick ? sel_q : disp_sel_q;
    if (state_q == NAV) begin
      if (btn_sel) begin
        choice_idx_d = sel_q;
        flash_cnt_d  = '0;
      end else if (btn_up && !btn_down) begin
        sel_d = (sel_q == '0) ? LAST : sel_q - SW'(1);
      end else if (btn_down && !btn_up) begin
        sel_d = (sel_q == LAST) ? '0 : sel_q + SW'(1);
      end
      if (frame_tick) begin
        if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt_d = '0;
          blink_on_d  = ~blink_on_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
      end
    end else begin
      // Held at the NAV entry values so the cursor reappears lit after a flash
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
      if (flash_done) begin
        choice_vld_d = 1'b1;
        flash_cnt_d  = '0;
      end else if (frame_tick) begin
        flash_cnt_d = flash_cnt_q + FW'(1);
      end
    end
  end

  always_comb begin
    hx         = {21'd0, hcount_in};
    vy         = {22'd0, vcount_in};
    top        = '0;
    in_box     = 1'b0;
    in_sel_box = 1'b0;
    in_border  = (vy < B_LO) || (vy >= B_RV) || (hx < B_LO) || (hx >= B_RH);
    for (int k = 0; k < N_ITEMS; k++) begin
      top = 32'(ITEM_Y0 + k * PITCH);
      if (hx >= X_LO && hx <= X_HI && vy >= top && vy < top + 32'(ITEM_H)) begin
        in_box = 1'b1;
        if (SW'(k) == disp_sel_q) in_sel_box = 1'b1;
      end
    end
    if (hblnk_in || vblnk_in)   rgb_d = 12'h000;
    else if (in_border)         rgb_d = BORDER_COLOR;
    else if (in_sel_box)        rgb_d = (state_q == FLASH) ? CONF_COLOR :
                                        (blink_on_q ? SEL_COLOR : ITEM_COLOR);
    else if (in_box)            rgb_d = ITEM_COLOR;
    else                        rgb_d = BG_COLOR;
  end

  assign hcount_out   = hcount_q;
  assign vcount_out   = vcount_q;
  assign hsync_out    = hsync_q;
  assign vsync_out    = vsync_q;
  assign hblnk_out    = hblnk_q;
  assign vblnk_out    = vblnk_q;
  assign rgb_out      = rgb_q;
  assign sel_index    = sel_q;
  assign choice_valid = choice_vld_q;
  assign choice_index = choice_idx_q;
endmodule

// File: tb/tb_menu_panel_draw.sv
// Directed bench for menu_panel_draw: sparse pixel samples stand in for full frames,
// each vblank pixel supplies one frame edge; expected pixels go through a scoreboard queue.
module tb_menu_panel_draw;
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic        btn_up, btn_down, btn_sel;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [1:0]  sel_index, choice_index;
  logic        choice_valid;

  int checks = 0;
  int errors = 0;
  int ticks  = 0;

  typedef struct packed {
    logic [11:0] rgb;
    logic [24:0] tim;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  menu_panel_draw dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .sel_index(sel_index),
    .choice_valid(choice_valid), .choice_index(choice_index)
  );

  localparam logic [11:0] C_BRD = 12'hF00, C_BG = 12'h888, C_ITEM = 12'h444;
  localparam logic [11:0] C_SEL = 12'hFF0, C_CONF = 12'h0F0, C_BLK = 12'h000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tim_out();
    return 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out});
  endfunction

  task automatic drive(input int h, input int v);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    hblnk_in  = (h >= 1024);
    vblnk_in  = (v >= 768);
    hsync_in  = (h >= 1048 && h < 1184);
    vsync_in  = (v >= 771 && v < 777);
  endtask

  // One pixel through the DUT: expectation queued at drive time, checked one clock later
  task automatic px(input string tag, input int h, input int v, input logic [11:0] exp_rgb);
    exp_t e;
    exp_t got;
    drive(h, v);
    e.rgb = exp_rgb;
    e.tim = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
    sb.push_back(e);
    @(posedge clk);
    #1;
    btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
    got = sb.pop_front();
    chk({tag, "_rgb"}, 32'(rgb_out), 32'(got.rgb));
    chk({tag, "_tim"}, tim_out(), 32'(got.tim));
  endtask

  task automatic btn(input string tag, input logic u, input logic d, input logic s,
                     input int h, input int v, input logic [11:0] exp_rgb);
    btn_up = u; btn_down = d; btn_sel = s;
    px(tag, h, v, exp_rgb);
  endtask

  task automatic frame();
    px("vbl", 0, 770, C_BLK);
    ticks++;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    drive(400, 402);
    hsync_in = 1'b1; vsync_in = 1'b1; btn_down = 1'b1; btn_up = 1'b0; btn_sel = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_rgb"}, 32'(rgb_out), 32'd0);
    chk({tag, "_tim"}, tim_out(), 32'd0);
    chk({tag, "_sel"}, 32'(sel_index), 32'd0);
    chk({tag, "_cv"}, 32'(choice_valid), 32'd0);
    chk({tag, "_ci"}, 32'(choice_index), 32'd0);
    rst = 1'b0; btn_down = 1'b0;
  endtask

  initial begin
    btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
    do_reset("reset");

    // Frame 0 geometry, border/box edges and blanking
    px("corner_tl", 0, 0, C_BRD);
    px("corner_br", 1023, 767, C_BRD);
    px("bg", 5, 5, C_BG);
    px("brd_col2", 2, 100, C_BRD);
    px("bg_col3", 3, 100, C_BG);
    px("bg_col1020", 1020, 100, C_BG);
    px("brd_col1021", 1021, 100, C_BRD);
    px("brd_row765", 100, 765, C_BRD);
    px("box0_sel", 400, 210, C_SEL);
    px("box1", 400, 300, C_ITEM);
    px("box0_tl", 384, 200, C_SEL);
    px("left_of_box0", 383, 200, C_BG);
    px("box0_br", 639, 263, C_SEL);
    px("right_of_box0", 640, 263, C_BG);
    px("gap01", 400, 264, C_BG);
    px("box3_bot", 400, 551, C_ITEM);
    px("below_box3", 400, 552, C_BG);
    px("hblank", 1100, 100, C_BLK);

    // Cursor wrap and simultaneous buttons; display holds box 0 until the frame edge
    btn("up_wrap", 1'b1, 1'b0, 1'b0, 400, 210, C_SEL);
    chk("sel_up_wrap", 32'(sel_index), 32'd3);
    btn("down_wrap", 1'b0, 1'b1, 1'b0, 400, 210, C_SEL);
    chk("sel_down_wrap", 32'(sel_index), 32'd0);
    btn("down", 1'b0, 1'b1, 1'b0, 400, 210, C_SEL);
    chk("sel_down", 32'(sel_index), 32'd1);
    btn("up_down", 1'b1, 1'b1, 1'b0, 400, 210, C_SEL);
    chk("sel_both", 32'(sel_index), 32'd1);
    px("old_box0", 400, 210, C_SEL);
    px("old_box1", 400, 306, C_ITEM);
    frame();
    px("new_box0", 400, 210, C_ITEM);
    px("new_box1", 400, 306, C_SEL);

    // Blink phases: lit for ticks 0..29, dark for 30..59, lit again from 60
    while (ticks < 62) begin
      px("blink", 400, 306, ((ticks / 30) % 2 == 0) ? C_SEL : C_ITEM);
      frame();
    end

    // Move to item 2 and confirm it
    btn("down_to2", 1'b0, 1'b1, 1'b0, 400, 306, C_SEL);
    chk("sel_two", 32'(sel_index), 32'd2);
    frame();
    px("box2_sel", 400, 402, C_SEL);
    btn("sel_press", 1'b0, 1'b0, 1'b1, 400, 402, C_SEL);
    chk("choice_latched", 32'(choice_index), 32'd2);
    for (int i = 0; i < 20; i++) begin
      px("flash_box2", 400, 402, C_CONF);
      px("flash_box1", 400, 306, C_ITEM);
      if (i == 3) begin
        btn("flash_up", 1'b1, 1'b0, 1'b0, 400, 402, C_CONF);
        chk("flash_sel_hold", 32'(sel_index), 32'd2);
      end
      if (i == 5) begin
        btn("flash_resel", 1'b0, 1'b0, 1'b1, 400, 402, C_CONF);
        chk("flash_down_hold", 32'(sel_index), 32'd2);
      end
      chk("cv_before_tick", 32'(choice_valid), 32'd0);
      frame();
      chk("cv_at_tick", 32'(choice_valid), 32'(i == 19));
      px("vsync", 1100, 772, C_BLK);
      chk("cv_after_tick", 32'(choice_valid), 32'd0);
    end
    chk("choice_idx", 32'(choice_index), 32'd2);
    px("nav_again", 400, 402, C_SEL);
    chk("choice_idx_hold", 32'(choice_index), 32'd2);

    // Reset in the middle of a flash aborts it with no pulse
    btn("sel_press2", 1'b0, 1'b0, 1'b1, 400, 402, C_SEL);
    for (int i = 0; i < 10; i++) begin
      px("flash2_box2", 400, 402, C_CONF);
      frame();
      chk("cv_flash2", 32'(choice_valid), 32'd0);
    end
    px("flash2_f10", 400, 402, C_CONF);
    do_reset("rst_flash");
    for (int i = 0; i < 25; i++) begin
      px("post_rst_box0", 400, 210, C_SEL);
      px("post_rst_box2", 400, 402, C_ITEM);
      frame();
      chk("post_rst_cv", 32'(choice_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
